// File: rtl/micro_op_queue_pkg.sv
`default_nettype none
// ==== DecoderTypes : micro-op types and jump classification shared by decode/execute (rev 1.0) ====
package DecoderTypes;

  parameter int UOPQ_DEPTH = 8;

  typedef enum logic [3:0] {
    M_NOP  = 4'd0,
    M_ADD  = 4'd1,
    M_SUB  = 4'd2,
    M_LD   = 4'd3,
    M_ST   = 4'd4,
    M_JMIN = 4'd5,
    M_JZ   = 4'd6,
    M_JNZ  = 4'd7,
    M_JMP  = 4'd8,
    M_JMAX = 4'd9
  } micro_opcode_t;

  typedef struct packed {
    micro_opcode_t opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [15:0]   imm;
  } micro_op_t;

  // Bounds are exclusive so M_JMIN/M_JMAX can act as range markers.
  function automatic logic is_jump(input micro_opcode_t op);
    return (op > M_JMIN) && (op < M_JMAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/micro_op_queue_if.sv
`default_nettype none
// ==== micro_op_queue_if : decoder-to-register-read micro-op queue bundle (rev 1.0) ====
interface micro_op_queue_if import DecoderTypes::*; #(
  parameter int DEPTH = UOPQ_DEPTH
);
  logic                     flush;
  logic [1:0]               in_count;
  micro_op_t                in_uop0;
  micro_op_t                in_uop1;
  logic                     in_ready;
  logic                     out_valid;
  micro_op_t                out_uop;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   occupancy;
  logic                     jmp_pending;

  modport master (
    output flush, in_count, in_uop0, in_uop1, out_ready,
    input  in_ready, out_valid, out_uop, occupancy, jmp_pending
  );

  modport slave (
    input  flush, in_count, in_uop0, in_uop1, out_ready,
    output in_ready, out_valid, out_uop, occupancy, jmp_pending
  );
endinterface
`default_nettype wire

// File: rtl/micro_op_queue.sv
`default_nettype none
// ==== micro_op_queue : 2-wide push / 1-wide pop micro-op FIFO with pending-jump count (rev 1.0) ====
module micro_op_queue import DecoderTypes::*; #(
  parameter int DEPTH = UOPQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  micro_op_queue_if.slave   q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] P_ONE   = AW'(1);
  localparam logic [CW-1:0] C_LIMIT = CW'(DEPTH - 2);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("micro_op_queue: DEPTH must be a power of two and at least 4");
  end

  micro_op_t     mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d, jcnt_q, jcnt_d;
  logic [CW-1:0] push_n, pop_n, jin_n, jout_n;
  logic          in_ready, out_valid, push0, push1, pop;

  // in_ready looks only at registered occupancy so it never depends on out_ready.
  assign in_ready  = (occ_q <= C_LIMIT);
  assign out_valid = (occ_q != '0);
  assign push0     = in_ready && (q.in_count == 2'd1 || q.in_count == 2'd2);
  assign push1     = in_ready && (q.in_count == 2'd2);
  assign pop       = out_valid && q.out_ready;

  assign q.in_ready    = in_ready;
  assign q.out_valid   = out_valid;
  assign q.out_uop     = mem_q[head_q];
  assign q.occupancy   = occ_q;
  assign q.jmp_pending = (jcnt_q != '0);

  always_comb begin
    push_n = {{(CW-1){1'b0}}, push0} + {{(CW-1){1'b0}}, push1};
    pop_n  = {{(CW-1){1'b0}}, pop};
    jin_n  = {{(CW-1){1'b0}}, push0 && is_jump(q.in_uop0.opcode)} +
             {{(CW-1){1'b0}}, push1 && is_jump(q.in_uop1.opcode)};
    jout_n = {{(CW-1){1'b0}}, pop && is_jump(q.out_uop.opcode)};
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    jcnt_d = jcnt_q;
    if (q.flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      jcnt_d = '0;
    end else begin
      head_d = pop ? head_q + P_ONE : head_q;
      tail_d = tail_q + push_n[AW-1:0];
      occ_d  = occ_q + push_n - pop_n;
      jcnt_d = jcnt_q + jin_n - jout_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      jcnt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      jcnt_q <= jcnt_d;
    end
  end

  // Payload storage carries no reset; entries are only meaningful below occupancy.
  always_ff @(posedge clk) begin
    if (!q.flush) begin
      if (push0) mem_q[tail_q]         <= q.in_uop0;
      if (push1) mem_q[tail_q + P_ONE] <= q.in_uop1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_op_queue.sv
`default_nettype none
// ==== tb_micro_op_queue : directed self-checking bench for micro_op_queue (rev 1.0) ====
module tb_micro_op_queue;
  import DecoderTypes::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  micro_op_queue_if #(.DEPTH(8)) q ();
  micro_op_queue #(.DEPTH(8)) dut (.clk(clk), .reset_n(reset_n), .q(q.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] n, input micro_opcode_t o0, input logic [15:0] i0,
                       input micro_opcode_t o1, input logic [15:0] i1);
    q.in_count = n;
    q.in_uop0  = '{opcode: o0, rd: 5'd1, rs1: 5'd2, imm: i0};
    q.in_uop1  = '{opcode: o1, rd: 5'd3, rs1: 5'd4, imm: i1};
  endtask

  task automatic idle();
    q.in_count  = 2'd0;
    q.out_ready = 1'b0;
    q.flush     = 1'b0;
  endtask

  initial begin
    int sent;
    int got;
    reset_n = 1'b0;
    idle();
    offer(2'd0, M_NOP, 16'd0, M_NOP, 16'd0);
    step();
    step();
    chk("rst_out_valid", 32'(q.out_valid), 32'd0);
    chk("rst_in_ready", 32'(q.in_ready), 32'd1);
    chk("rst_occ", 32'(q.occupancy), 32'd0);
    chk("rst_jmp", 32'(q.jmp_pending), 32'd0);
    reset_n = 1'b1;

    // basic 2-push then two pops
    offer(2'd2, M_ADD, 16'd1, M_LD, 16'd2);
    step();
    idle();
    chk("b_valid", 32'(q.out_valid), 32'd1);
    chk("b_op0", 32'(q.out_uop.opcode), 32'(M_ADD));
    chk("b_occ", 32'(q.occupancy), 32'd2);
    q.out_ready = 1'b1;
    step();
    chk("b_op1", 32'(q.out_uop.opcode), 32'(M_LD));
    chk("b_imm1", 32'(q.out_uop.imm), 32'd2);
    step();
    chk("b_empty", 32'(q.out_valid), 32'd0);
    chk("b_occ0", 32'(q.occupancy), 32'd0);
    idle();

    // fill to full, ignored push, then in_ready recovery
    for (int i = 0; i < 4; i++) begin
      offer(2'd2, M_ADD, 16'(10 + 2*i), M_SUB, 16'(11 + 2*i));
      step();
    end
    chk("f_occ8", 32'(q.occupancy), 32'd8);
    chk("f_rdy0", 32'(q.in_ready), 32'd0);
    offer(2'd2, M_JZ, 16'd99, M_JZ, 16'd98);
    step();
    chk("f_ign_occ", 32'(q.occupancy), 32'd8);
    chk("f_ign_jmp", 32'(q.jmp_pending), 32'd0);
    chk("f_head", 32'(q.out_uop.imm), 32'd10);
    idle();
    q.out_ready = 1'b1;
    step();
    chk("f_occ7", 32'(q.occupancy), 32'd7);
    chk("f_rdy7", 32'(q.in_ready), 32'd0);
    step();
    chk("f_occ6", 32'(q.occupancy), 32'd6);
    chk("f_rdy6", 32'(q.in_ready), 32'd1);
    chk("f_head12", 32'(q.out_uop.imm), 32'd12);
    for (int i = 0; i < 6; i++) step();
    chk("f_drained", 32'(q.out_valid), 32'd0);
    idle();

    // streaming with random out_ready; pointers wrap twice
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      q.in_count = 2'd0;
      if (q.in_ready && sent < 20) begin
        offer((20 - sent >= 2) ? 2'd2 : 2'd1, M_ADD, 16'(sent), M_ADD, 16'(sent + 1));
        sent += int'(q.in_count);
      end
      q.out_ready = 1'($urandom_range(0, 1));
      if (q.out_valid && q.out_ready) begin
        chk("s_order", 32'(q.out_uop.imm), 32'(got));
        got++;
      end
      step();
    end
    idle();
    chk("s_count", 32'(got), 32'd20);
    chk("s_occ0", 32'(q.occupancy), 32'd0);

    // simultaneous push 2 / pop 1 at occupancy 6
    for (int i = 0; i < 3; i++) begin
      offer(2'd2, M_ADD, 16'(i), M_ADD, 16'(i));
      step();
    end
    chk("c_occ6", 32'(q.occupancy), 32'd6);
    q.out_ready = 1'b1;
    step();
    idle();
    chk("c_occ7", 32'(q.occupancy), 32'd7);
    chk("c_rdy0", 32'(q.in_ready), 32'd0);
    q.flush = 1'b1;
    step();
    idle();
    chk("c_fl_occ", 32'(q.occupancy), 32'd0);
    chk("c_fl_rdy", 32'(q.in_ready), 32'd1);

    // jump counter and flush during push+pop
    offer(2'd2, M_JZ, 16'd1, M_ADD, 16'd2);
    step();
    q.in_count = 2'd0;
    chk("j_pend1", 32'(q.jmp_pending), 32'd1);
    q.out_ready = 1'b1;
    step();
    idle();
    chk("j_head_add", 32'(q.out_uop.opcode), 32'(M_ADD));
    chk("j_pend0", 32'(q.jmp_pending), 32'd0);
    offer(2'd2, M_JMP, 16'd3, M_ADD, 16'd4);
    step();
    offer(2'd2, M_JNZ, 16'd5, M_ST, 16'd6);
    step();
    chk("j_occ5", 32'(q.occupancy), 32'd5);
    chk("j_pend2", 32'(q.jmp_pending), 32'd1);
    offer(2'd2, M_JZ, 16'd7, M_JZ, 16'd8);
    q.out_ready = 1'b1;
    q.flush     = 1'b1;
    step();
    idle();
    chk("j_fl_occ", 32'(q.occupancy), 32'd0);
    chk("j_fl_valid", 32'(q.out_valid), 32'd0);
    chk("j_fl_jmp", 32'(q.jmp_pending), 32'd0);
    chk("j_fl_rdy", 32'(q.in_ready), 32'd1);
    offer(2'd2, M_JMIN, 16'd0, M_JMAX, 16'd0);
    step();
    idle();
    chk("j_bounds", 32'(q.jmp_pending), 32'd0);
    chk("j_bounds_occ", 32'(q.occupancy), 32'd2);
    q.out_ready = 1'b1;
    step();
    step();
    idle();
    offer(2'd2, M_JZ, 16'd0, M_JNZ, 16'd0);
    step();
    q.in_count  = 2'd0;
    q.out_ready = 1'b1;
    step();
    chk("j_two_left", 32'(q.jmp_pending), 32'd1);
    step();
    idle();
    chk("j_two_done", 32'(q.jmp_pending), 32'd0);
    offer(2'd3, M_JZ, 16'd0, M_JZ, 16'd0);
    step();
    idle();
    chk("cnt3_occ", 32'(q.occupancy), 32'd0);
    chk("cnt3_jmp", 32'(q.jmp_pending), 32'd0);

    // asynchronous reset between edges at occupancy 4
    offer(2'd2, M_JZ, 16'd1, M_ADD, 16'd2);
    step();
    offer(2'd2, M_ADD, 16'd3, M_ADD, 16'd4);
    step();
    idle();
    chk("r_occ4", 32'(q.occupancy), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("r_valid", 32'(q.out_valid), 32'd0);
    chk("r_occ", 32'(q.occupancy), 32'd0);
    chk("r_rdy", 32'(q.in_ready), 32'd1);
    chk("r_jmp", 32'(q.jmp_pending), 32'd0);
    #1;
    reset_n = 1'b1;
    offer(2'd1, M_ADD, 16'h55, M_JZ, 16'h66);
    step();
    idle();
    chk("r_post_valid", 32'(q.out_valid), 32'd1);
    chk("r_post_imm", 32'(q.out_uop.imm), 32'h55);
    chk("r_post_occ", 32'(q.occupancy), 32'd1);
    chk("r_post_jmp", 32'(q.jmp_pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/micro_op_queue.md
MICRO_OP_QUEUE -- requirements
Module: micro_op_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of micro_op_t entries; it SHALL be a power of two and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port flush, input, 1 bit: discard all queued micro-ops (redirect after jump resolution).
REQ-005 SHALL have port in_count, input, 2 bits: number of valid micro-ops offered by the decoder this cycle (0..2).
REQ-006 SHALL have ports in_uop0 and in_uop1, input, micro_op_t: offered micro-ops; in_uop0 is older.
REQ-007 SHALL have port in_ready, output, 1 bit: at least 2 free slots.
REQ-008 SHALL have port out_valid, output, 1 bit: queue is non-empty.
REQ-009 SHALL have port out_uop, output, micro_op_t: oldest entry.
REQ-010 SHALL have port out_ready, input, 1 bit: register-read stage accepts out_uop.
REQ-011 SHALL have port occupancy, output, $clog2(DEPTH)+1 bits: current entry count.
REQ-012 SHALL have port jmp_pending, output, 1 bit: at least one queued opcode lies strictly between M_JMIN and M_JMAX.

Function
REQ-013 SHALL accept a push when in_ready=1 and in_count is 1 or 2, writing in_uop0 then in_uop1 at consecutive tail slots.
REQ-014 SHALL treat in_count=3 as 0, and SHALL ignore any push offered while in_ready=0, with no state change from it.
REQ-015 SHALL pop when out_valid=1 and out_ready=1, advancing head by one.
REQ-016 SHALL derive in_ready from registered occupancy only (DEPTH-occupancy >= 2), never combinationally from out_ready.
REQ-017 SHALL allow push and pop in the same cycle, with next occupancy = occupancy + pushed - popped.
REQ-018 SHALL have push-to-out_valid latency of one cycle, with no bypass of an empty queue.
REQ-019 SHALL drive out_uop from storage at head, and its value SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 SHALL wrap head and tail pointers modulo DEPTH, with full and empty distinguished by occupancy and not by pointer equality.
REQ-021 SHALL preserve strict FIFO order across wrap-around.
REQ-022 SHALL maintain a jump counter: +1 for each accepted jump micro-op (up to +2 per cycle), -1 when a popped micro-op is a jump; jmp_pending is counter != 0.
REQ-023 SHALL give flush top priority: head, tail, occupancy and jump counter SHALL clear at the next edge, and any push or pop in that cycle SHALL be discarded.
REQ-024 SHALL, after a flush, hold out_valid=0 and in_ready=1 in the following cycle.
REQ-025 SHALL not clear storage contents on flush or reset; they are don't-care while out_valid=0.

Reset
REQ-026 SHALL, on reset_n low at any time including mid-transfer, immediately clear head, tail, occupancy and jump counter, independent of clk.
REQ-027 SHALL, during and after reset, drive out_valid=0, in_ready=1, occupancy=0 and jmp_pending=0 until the first accepted push.

Structure
REQ-028 SHALL take micro_op_t and micro_opcode_t, including M_JMIN and M_JMAX, from package DecoderTypes; the is-jump test SHALL be a function in DecoderTypes shared with the execute stage.
REQ-029 SHALL place default constant UOPQ_DEPTH = 8 in DecoderTypes.
REQ-030 SHALL be a single module with no sub-module; storage SHALL be a DEPTH-entry micro_op_t array.

Verification (DEPTH=8)
REQ-031 SHALL cover: reset; push m_add,m_ld with in_count=2 -> next cycle out_valid=1, out_uop.opcode=m_add, occupancy=2; pop -> m_ld; pop -> out_valid=0.
REQ-032 SHALL cover: four 2-pushes with no pops -> occupancy=8, in_ready=0; fifth 2-push ignored; one pop -> occupancy=7, in_ready still 0; second pop -> in_ready=1.
REQ-033 SHALL cover: stream 20 uops with rising immediate values 0..19 through random out_ready -> output order 0..19, pointers wrap twice, no loss or duplication.
REQ-034 SHALL cover: occupancy=6, push 2 and pop 1 in the same cycle -> occupancy=7, in_ready=0.
REQ-035 SHALL cover: push m_jz and m_add -> jmp_pending=1; pop m_jz -> jmp_pending=0; then flush during simultaneous push and pop at occupancy=5 -> occupancy=0, out_valid=0, jmp_pending=0.
REQ-036 SHALL cover: assert reset_n low between clock edges at occupancy=4 -> outputs clear immediately; push after release -> normal operation.
